ctrl_step_sequencer: RTL



---
 rtl/cpu_ctrl_pkg.sv | 54 +++++
 rtl/ctrl_op_class.sv | 32 +++
 rtl/ctrl_step_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hard-wired control unit: opcodes, ALU function
// codes, step states and instruction classes.
package cpu_ctrl_pkg;

    localparam int OPW_C  = 5;
    localparam int ALUW_C = 4;

    localparam logic [OPW_C-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW_C-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW_C-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW_C-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW_C-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW_C-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW_C-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPW_C-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPW_C-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW_C-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW_C-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW_C-1:0] OP_NOP  = 5'b11000;
    localparam logic [OPW_C-1:0] OP_HALT = 5'b11001;

    localparam logic [ALUW_C-1:0] ALU_NOP = 4'd0;
    localparam logic [ALUW_C-1:0] ALU_ADD = 4'd1;
    localparam logic [ALUW_C-1:0] ALU_SUB = 4'd2;
    localparam logic [ALUW_C-1:0] ALU_AND = 4'd3;
    localparam logic [ALUW_C-1:0] ALU_OR  = 4'd4;
    localparam logic [ALUW_C-1:0] ALU_SHR = 4'd5;
    localparam logic [ALUW_C-1:0] ALU_SHL = 4'd6;
    localparam logic [ALUW_C-1:0] ALU_INC = 4'd7;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } step_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_ST,
        CLS_NOP,
        CLS_HALT,
        CLS_ILL
    } op_class_t;

endpackage

// File: rtl/ctrl_op_class.sv
// Combinational opcode decode: instruction class plus the ALU function the
// execute step should request for R-type and I-type instructions.
module ctrl_op_class
    import cpu_ctrl_pkg::*;
(
    input  logic [OPW_C-1:0]  ir_op,
    output op_class_t         op_class,
    output logic [ALUW_C-1:0] alu_op
);

    always_comb begin
        op_class = CLS_ILL;
        alu_op   = ALU_NOP;
        case (ir_op)
            OP_ADD:  begin op_class = CLS_R;    alu_op = ALU_ADD; end
            OP_SUB:  begin op_class = CLS_R;    alu_op = ALU_SUB; end
            OP_AND:  begin op_class = CLS_R;    alu_op = ALU_AND; end
            OP_OR:   begin op_class = CLS_R;    alu_op = ALU_OR;  end
            OP_SHR:  begin op_class = CLS_R;    alu_op = ALU_SHR; end
            OP_SHL:  begin op_class = CLS_R;    alu_op = ALU_SHL; end
            OP_ADDI: begin op_class = CLS_I;    alu_op = ALU_ADD; end
            OP_ANDI: begin op_class = CLS_I;    alu_op = ALU_AND; end
            OP_ORI:  begin op_class = CLS_I;    alu_op = ALU_OR;  end
            OP_LD:   begin op_class = CLS_LD;   alu_op = ALU_ADD; end
            OP_ST:   begin op_class = CLS_ST;   alu_op = ALU_ADD; end
            OP_NOP:  op_class = CLS_NOP;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/ctrl_step_sequencer.sv
// Hard-wired step sequencer: fetch (T0..T2) then class-specific execute steps,
// with memory handshake waits in T1 (fetch read), T6 (ld read) and T7 (st write).
module ctrl_step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = OPW_C,
    parameter int ALUW = ALUW_C
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            start,
    input  logic            mem_ack,
    input  logic [OPW-1:0]  ir_op,
    output logic            pc_out,
    output logic            mar_in,
    output logic            inc_pc,
    output logic            z_in,
    output logic            zlow_out,
    output logic            pc_in,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            ir_in,
    output logic            y_in,
    output logic            c_out,
    output logic            read,
    output logic            write,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            rin,
    output logic            rout,
    output logic            baout,
    output logic [ALUW-1:0] alu_op,
    output logic            run,
    output logic            illegal,
    output logic [3:0]      step
);

    step_t              state_reg;
    step_t              state_next;
    logic               illegal_reg;
    op_class_t          op_class;
    logic [ALUW_C-1:0]  class_alu;

    ctrl_op_class u_op_class (
        .ir_op    (ir_op),
        .op_class (op_class),
        .alu_op   (class_alu)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   if (mem_ack) state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3: begin
                case (op_class)
                    CLS_R, CLS_I, CLS_LD, CLS_ST: state_next = S_T4;
                    CLS_HALT:                     state_next = S_HALT;
                    default:                      state_next = S_T0;
                endcase
            end
            S_T4:   state_next = S_T5;
            S_T5:   state_next = (op_class == CLS_LD || op_class == CLS_ST) ? S_T6 : S_T0;
            S_T6: begin
                if (op_class == CLS_ST || mem_ack) state_next = S_T7;
            end
            S_T7: begin
                if (op_class != CLS_ST || mem_ack) state_next = S_T0;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg   <= S_IDLE;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_T3 && op_class == CLS_ILL)
                illegal_reg <= 1'b1;
        end
    end

    // Strobes come only from the state register and the (registered) IR field,
    // so they change cleanly at step boundaries; clear drops them at once.
    always_comb begin
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        inc_pc   = 1'b0;
        z_in     = 1'b0;
        zlow_out = 1'b0;
        pc_in    = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        c_out    = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        gra      = 1'b0;
        grb      = 1'b0;
        grc      = 1'b0;
        rin      = 1'b0;
        rout     = 1'b0;
        baout    = 1'b0;
        alu_op   = ALU_NOP;
        case (state_reg)
            S_T0: begin
                pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
                alu_op = ALU_INC;
            end
            S_T1: begin
                zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1; ir_in = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    CLS_R, CLS_I:   begin grb = 1'b1; rout = 1'b1;  y_in = 1'b1; end
                    CLS_LD, CLS_ST: begin grb = 1'b1; baout = 1'b1; y_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CLS_R: begin
                        grc = 1'b1; rout = 1'b1; z_in = 1'b1; alu_op = class_alu;
                    end
                    CLS_I, CLS_LD, CLS_ST: begin
                        c_out = 1'b1; z_in = 1'b1; alu_op = class_alu;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    CLS_R, CLS_I:   begin zlow_out = 1'b1; gra = 1'b1; rin = 1'b1; end
                    CLS_LD, CLS_ST: begin zlow_out = 1'b1; mar_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_class)
                    CLS_LD:  begin read = 1'b1; mdr_in = 1'b1; end
                    CLS_ST:  begin gra = 1'b1; rout = 1'b1; mdr_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_class)
                    CLS_LD:  begin mdr_out = 1'b1; gra = 1'b1; rin = 1'b1; end
                    CLS_ST:  write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign run     = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign illegal = illegal_reg;
    assign step    = state_reg;

endmodule
